// File: rtl/rf_dbg_pkg.sv
// Shared types and widths for the register-file debug/boot access port.
package rf_dbg_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 5;

  // Sequencer states: idle, streaming writes in, streaming reads out, completion pulse.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DUMP   = 2'd2,
    ST_FINISH = 2'd3
  } dbg_state_e;

  // One DUMP beat: register index plus its contents.
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] data;
  } dump_word_t;

endpackage

// File: rtl/rf_debug_port.sv
// Debug/boot access port: loads the register file from a word stream or
// dumps it as {index, data} beats, stalling the core while active.
module rf_debug_port
  import rf_dbg_pkg::*;
#(
  parameter int unsigned FIRST_REG = 1,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              dump_start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  input  logic              out_ready,
  output logic              dbg_wenable,
  output logic [IDX_W-1:0]  dbg_dest,
  output logic [WORD_W-1:0] dbg_wdata,
  output logic [IDX_W-1:0]  dbg_raddr,
  input  logic [WORD_W-1:0] dbg_rdata,
  output logic              busy,
  output logic              cpu_stall,
  output logic              done
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

  dbg_state_e        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_in_ready;
  logic              r_out_valid;
  dump_word_t        r_out;
  logic              r_last_filled;
  logic              r_wenable;
  logic [IDX_W-1:0]  r_dest;
  logic [WORD_W-1:0] r_wdata;
  logic [IDX_W-1:0]  r_raddr;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_dump_hs;
  logic              w_fill;
  logic              w_idx_last;

  // Handshake qualifiers; a fill may reuse the slot in the same cycle it drains.
  assign w_accept   = (r_state == ST_LOAD) && in_valid && r_in_ready;
  assign w_dump_hs  = r_out_valid && out_ready;
  assign w_fill     = (r_state == ST_DUMP) && !r_last_filled && (!r_out_valid || out_ready);
  assign w_idx_last = (r_idx == LAST_IDX);

  // Sequencer: state, index counter, write-pulse register and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= FIRST_IDX;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out         <= '0;
      r_last_filled <= 1'b0;
      r_wenable     <= 1'b0;
      r_dest        <= '0;
      r_wdata       <= '0;
      r_raddr       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else if (abort && (r_state != ST_IDLE)) begin
      // Abort drops everything in flight; writes already landed stay in the RF.
      r_state       <= ST_IDLE;
      r_idx         <= FIRST_IDX;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out         <= '0;
      r_last_filled <= 1'b0;
      r_wenable     <= 1'b0;
      r_dest        <= '0;
      r_wdata       <= '0;
      r_raddr       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_wenable <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_start) begin
            r_state    <= ST_LOAD;
            r_idx      <= FIRST_IDX;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end else if (dump_start) begin
            r_state       <= ST_DUMP;
            r_idx         <= FIRST_IDX;
            r_raddr       <= FIRST_IDX;
            r_last_filled <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_wenable <= 1'b1;
            r_dest    <= r_idx;
            r_wdata   <= in_data;
            if (w_idx_last) begin
              // Final write pulse overlaps the FINISH cycle.
              r_state    <= ST_FINISH;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        ST_DUMP: begin
          if (w_fill) begin
            r_out       <= '{idx: r_idx, data: dbg_rdata};
            r_out_valid <= 1'b1;
            if (w_idx_last) begin
              r_last_filled <= 1'b1;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_raddr <= r_idx + IDX_W'(1);
            end
          end else if (w_dump_hs) begin
            // Only reachable once the last entry is filled and now consumed.
            r_out_valid <= 1'b0;
            r_raddr     <= '0;
            r_state     <= ST_FINISH;
            r_done      <= 1'b1;
          end
        end
        ST_FINISH: begin
          r_state       <= ST_IDLE;
          r_idx         <= FIRST_IDX;
          r_busy        <= 1'b0;
          r_dest        <= '0;
          r_wdata       <= '0;
          r_out         <= '0;
          r_last_filled <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Port mapping of the registered state; the stall is the busy flag itself.
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out.data;
  assign out_index   = r_out.idx;
  assign dbg_wenable = r_wenable;
  assign dbg_dest    = r_dest;
  assign dbg_wdata   = r_wdata;
  assign dbg_raddr   = r_raddr;
  assign busy        = r_busy;
  assign cpu_stall   = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_rf_debug_port.sv
// Directed bench for rf_debug_port with a negedge-write register-file model.
module tb_rf_debug_port;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic        dump_start;
  logic        abort;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_ready;
  logic        dbg_wenable;
  logic [4:0]  dbg_dest;
  logic [31:0] dbg_wdata;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        busy;
  logic        cpu_stall;
  logic        done;

  logic [31:0] rf [0:31];
  logic        rf_init;

  int n_cmp;
  int n_err;

  rf_debug_port #(.FIRST_REG(1), .LAST_REG(31)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .dump_start(dump_start),
    .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .out_ready(out_ready), .dbg_wenable(dbg_wenable), .dbg_dest(dbg_dest),
    .dbg_wdata(dbg_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .busy(busy), .cpu_stall(cpu_stall), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: writes land on negedge, read port is combinational.
  always @(negedge clk) begin
    if (rf_init) begin
      for (int k = 0; k < 32; k++) rf[k] <= 32'hDEAD_0000 + 32'(k);
    end else if (dbg_wenable) begin
      rf[dbg_dest] <= dbg_wdata;
    end
  end
  assign dbg_rdata = rf[dbg_raddr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [84:0] outs;
    rst = 1'b1; rf_init = 1'b1;
    load_start = 0; dump_start = 0; abort = 0; in_valid = 0; in_data = '0; out_ready = 0;
    repeat (3) tick();
    outs = {in_ready, out_valid, out_data, out_index, dbg_wenable, dbg_dest,
            dbg_wdata, dbg_raddr, busy, cpu_stall, done};
    n_cmp++;
    if (outs !== 85'd0) begin n_err++; $display("FAIL reset_state got=%h exp=0", outs); end
    rst = 1'b0; rf_init = 1'b0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || cpu_stall !== 1'b1) begin
      n_err++; $display("FAIL load_entry busy=%b in_ready=%b stall=%b exp=1,1,1", busy, in_ready, cpu_stall);
    end
    #2 rst = 1'b1;
    #1;
    outs = {in_ready, out_valid, out_data, out_index, dbg_wenable, dbg_dest,
            dbg_wdata, dbg_raddr, busy, cpu_stall, done};
    n_cmp++;
    if (outs !== 85'd0) begin n_err++; $display("FAIL async_reset got=%h exp=0", outs); end
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_load_b2b();
    int   wen_cycles;
    logic exp_done;
    wen_cycles = 0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      in_valid = 1'b1; in_data = 32'h1000_0000 + 32'(i);
      tick();
      exp_done = (i == 31);
      if (dbg_wenable === 1'b1) wen_cycles++;
      n_cmp++;
      if (dbg_wenable !== 1'b1 || dbg_dest !== 5'(i) || dbg_wdata !== 32'h1000_0000 + 32'(i) || done !== exp_done) begin
        n_err++;
        $display("FAIL load_b2b_write i=%0d wen=%b dest=%0d data=%h done=%b exp wen=1 dest=%0d data=%h done=%b",
                 i, dbg_wenable, dbg_dest, dbg_wdata, done, i, 32'h1000_0000 + 32'(i), exp_done);
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (wen_cycles != 31) begin n_err++; $display("FAIL load_b2b_wen_cycles got=%0d exp=31", wen_cycles); end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || dbg_wenable !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL load_b2b_idle done=%b busy=%b wen=%b in_ready=%b exp=0,0,0,0", done, busy, dbg_wenable, in_ready);
    end
    for (int i = 0; i <= 31; i++) begin
      n_cmp++;
      if (rf[i] !== ((i == 0) ? 32'hDEAD_0000 : 32'h1000_0000 + 32'(i))) begin
        n_err++; $display("FAIL load_b2b_rf r%0d got=%h exp=%h", i, rf[i], (i == 0) ? 32'hDEAD_0000 : 32'h1000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_load_gaps();
    logic exp_done;
    rf_init = 1'b1; tick(); rf_init = 1'b0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      in_valid = 1'b0;
      tick();
      n_cmp++;
      if (dbg_wenable !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL load_gap_idle i=%0d wen=%b busy=%b exp wen=0 busy=1", i, dbg_wenable, busy);
      end
      in_valid = 1'b1; in_data = 32'h1000_0000 + 32'(i);
      tick();
      exp_done = (i == 31);
      n_cmp++;
      if (dbg_wenable !== 1'b1 || dbg_dest !== 5'(i) || dbg_wdata !== 32'h1000_0000 + 32'(i) || done !== exp_done) begin
        n_err++;
        $display("FAIL load_gap_write i=%0d wen=%b dest=%0d data=%h done=%b exp wen=1 dest=%0d done=%b",
                 i, dbg_wenable, dbg_dest, dbg_wdata, done, i, exp_done);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL load_gap_end busy=%b done=%b exp=0,0", busy, done);
    end
    for (int i = 1; i <= 31; i++) begin
      n_cmp++;
      if (rf[i] !== 32'h1000_0000 + 32'(i)) begin
        n_err++; $display("FAIL load_gap_rf r%0d got=%h exp=%h", i, rf[i], 32'h1000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_dump();
    int          exp_idx;
    int          hs;
    logic        seen_done;
    logic        was_valid;
    logic        was_ready;
    logic [31:0] held_d;
    logic [4:0]  held_i;
    exp_idx = 1; hs = 0; seen_done = 1'b0;
    dump_start = 1'b1; tick(); dump_start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || dbg_raddr !== 5'd1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL dump_entry busy=%b in_ready=%b raddr=%0d ovalid=%b exp 1,0,1,0", busy, in_ready, dbg_raddr, out_valid);
    end
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      out_ready = (cyc % 2 == 0);
      was_valid = out_valid; was_ready = out_ready; held_d = out_data; held_i = out_index;
      tick();
      if (was_valid && was_ready) begin
        n_cmp++;
        if (held_i !== 5'(exp_idx) || held_d !== 32'h1000_0000 + 32'(exp_idx)) begin
          n_err++; $display("FAIL dump_beat idx=%0d data=%h exp idx=%0d data=%h", held_i, held_d, exp_idx, 32'h1000_0000 + 32'(exp_idx));
        end
        exp_idx++; hs++;
      end else if (was_valid) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_index !== held_i) begin
          n_err++; $display("FAIL dump_stall_stable v=%b idx=%0d data=%h exp v=1 idx=%0d data=%h", out_valid, out_index, out_data, held_i, held_d);
        end
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        n_cmp++;
        if (hs != 31 || !(was_valid && was_ready) || out_valid !== 1'b0) begin
          n_err++; $display("FAIL dump_done_timing hs=%0d last_hs=%b ovalid=%b exp hs=31 last_hs=1 ovalid=0", hs, was_valid && was_ready, out_valid);
        end
      end
    end
    out_ready = 1'b0;
    n_cmp++;
    if (!seen_done || hs != 31) begin n_err++; $display("FAIL dump_complete done_seen=%b hs=%0d exp 1,31", seen_done, hs); end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL dump_idle busy=%b done=%b exp 0,0", busy, done); end
  endtask

  task automatic test_priority();
    load_start = 1'b1; dump_start = 1'b1; tick(); load_start = 1'b0; dump_start = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || dbg_raddr !== 5'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL prio_load_wins in_ready=%b busy=%b raddr=%0d ovalid=%b exp 1,1,0,0", in_ready, busy, dbg_raddr, out_valid);
    end
    dump_start = 1'b1; tick(); dump_start = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || dbg_raddr !== 5'd0) begin
      n_err++; $display("FAIL prio_dump_ignored in_ready=%b busy=%b ovalid=%b raddr=%0d exp 1,1,0,0", in_ready, busy, out_valid, dbg_raddr);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || cpu_stall !== 1'b0) begin
      n_err++; $display("FAIL abort_load busy=%b in_ready=%b done=%b stall=%b exp 0,0,0,0", busy, in_ready, done, cpu_stall);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL prio_not_queued busy=%b ovalid=%b exp 0,0", busy, out_valid);
    end
  endtask

  task automatic test_abort_dump();
    logic       seen_done;
    logic       hit5;
    logic       was_valid;
    logic [4:0] was_idx;
    seen_done = 1'b0; hit5 = 1'b0;
    dump_start = 1'b1; tick(); dump_start = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && !hit5; cyc++) begin
      was_valid = out_valid; was_idx = out_index;
      tick();
      if (done === 1'b1) seen_done = 1'b1;
      if (was_valid && was_idx == 5'd5) hit5 = 1'b1;
    end
    n_cmp++;
    if (!hit5) begin n_err++; $display("FAIL abort_reach_idx5 got=0 exp=1"); end
    abort = 1'b1; tick(); abort = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || cpu_stall !== 1'b0 || dbg_raddr !== 5'd0) begin
      n_err++; $display("FAIL abort_dump ovalid=%b busy=%b stall=%b raddr=%0d exp 0,0,0,0", out_valid, busy, cpu_stall, dbg_raddr);
    end
    if (done === 1'b1) seen_done = 1'b1;
    repeat (5) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got=1 exp=0"); end
  endtask

  task automatic test_rst_load();
    logic [84:0] outs;
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 32'h5555_0000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (dbg_wenable !== 1'b1 || dbg_dest !== 5'd3) begin
      n_err++; $display("FAIL rst_load_third wen=%b dest=%0d exp 1,3", dbg_wenable, dbg_dest);
    end
    @(negedge clk); #1 rst = 1'b1;
    #1;
    outs = {in_ready, out_valid, out_data, out_index, dbg_wenable, dbg_dest,
            dbg_wdata, dbg_raddr, busy, cpu_stall, done};
    n_cmp++;
    if (outs !== 85'd0) begin n_err++; $display("FAIL rst_load_clear got=%h exp=0", outs); end
    @(negedge clk); rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (rf[i] !== ((i <= 3) ? 32'h5555_0000 + 32'(i) : 32'h1000_0004)) begin
        n_err++; $display("FAIL rst_load_rf r%0d got=%h exp=%h", i, rf[i], (i <= 3) ? 32'h5555_0000 + 32'(i) : 32'h1000_0004);
      end
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL rst_load_idle busy=%b in_ready=%b exp 0,0", busy, in_ready); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_load_b2b();
    test_load_gaps();
    test_dump();
    test_priority();
    test_abort_dump();
    test_rst_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
